// File: rtl/dpram_bist_ctrl.sv
// Two-pass write/read-back BIST sequencer for a single-clock dual-port RAM.
// Port A writes the pattern; port B reads it back, and a shift register lines reads up with dout_b.
module dpram_bist_ctrl #(
    parameter int          ADDR_W = 4,
    parameter int          DATA_W = 8,
    parameter logic [7:0]  SEED   = 8'hA5,
    parameter int          RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] din_a,
    output logic              we_a,
    output logic              re_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din_b,
    output logic              we_b,
    output logic              re_b,
    input  logic [DATA_W-1:0] dout_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W+1:0] err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = $clog2(RD_LAT+1) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

    typedef enum logic [2:0] {IDLE, WR1, RD1, DRN1, WR2, RD2, DRN2, DONE} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0] addr_a_n, addr_b_n, err_addr_n;
    logic [DATA_W-1:0] din_a_n, err_data_n;
    logic              we_a_n, re_b_n, busy_n, done_n, pass_n, fail_n, clr, mism;
    logic [ADDR_W+1:0] err_cnt_n;
    logic [CW-1:0]     drn_cnt, drn_n;

    // Stage 0 is loaded alongside re_b; stage RD_LAT lines up with dout_b.
    logic [RD_LAT:0]             vld_pipe;
    logic [RD_LAT:0][ADDR_W-1:0] adr_pipe;
    logic [RD_LAT:0][DATA_W-1:0] exp_pipe;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] k, input logic inv);
        logic [DATA_W-1:0] d;
        d = DATA_W'(k) ^ DATA_W'(SEED);
        return inv ? ~d : d;
    endfunction

    assign re_a  = 1'b0;
    assign we_b  = 1'b0;
    assign din_b = '0;
    assign mism  = vld_pipe[RD_LAT] && (dout_b != exp_pipe[RD_LAT]);

    always_comb begin
        state_n    = state;
        addr_a_n   = addr_a;
        din_a_n    = din_a;
        we_a_n     = we_a;
        addr_b_n   = addr_b;
        re_b_n     = re_b;
        busy_n     = busy;
        done_n     = done;
        pass_n     = pass;
        drn_n      = drn_cnt;
        clr        = 1'b0;
        fail_n     = fail;
        err_cnt_n  = err_cnt;
        err_addr_n = err_addr;
        err_data_n = err_data;
        case (state)
            IDLE: if (start) begin
                state_n  = WR1;
                busy_n   = 1'b1;
                done_n   = 1'b0;
                pass_n   = 1'b0;
                clr      = 1'b1;
                we_a_n   = 1'b1;
                addr_a_n = '0;
                din_a_n  = pat('0, 1'b0);
            end
            WR1, WR2: if (addr_a == LAST) begin
                state_n  = (state == WR1) ? RD1 : RD2;
                we_a_n   = 1'b0;
                re_b_n   = 1'b1;
                addr_b_n = '0;
            end else begin
                addr_a_n = addr_a + 1'b1;
                din_a_n  = pat(addr_a + 1'b1, state == WR2);
            end
            RD1, RD2: if (addr_b == LAST) begin
                state_n = (state == RD1) ? DRN1 : DRN2;
                re_b_n  = 1'b0;
            end else begin
                addr_b_n = addr_b + 1'b1;
            end
            DRN1, DRN2: if (drn_cnt == CW'(RD_LAT)) begin
                drn_n = '0;
                if (state == DRN1) begin
                    state_n  = WR2;
                    we_a_n   = 1'b1;
                    addr_a_n = '0;
                    din_a_n  = pat('0, 1'b1);
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = !(fail || mism);
                end
            end else begin
                drn_n = drn_cnt + 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clr) begin
            fail_n     = 1'b0;
            err_cnt_n  = '0;
            err_addr_n = '0;
            err_data_n = '0;
        end else if (mism) begin
            fail_n    = 1'b1;
            err_cnt_n = err_cnt + 1'b1;
            if (!fail) begin
                err_addr_n = adr_pipe[RD_LAT];
                err_data_n = dout_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_a   <= '0;
            din_a    <= '0;
            we_a     <= 1'b0;
            addr_b   <= '0;
            re_b     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            err_data <= '0;
            drn_cnt  <= '0;
            vld_pipe <= '0;
            adr_pipe <= '0;
            exp_pipe <= '0;
        end else begin
            state    <= state_n;
            addr_a   <= addr_a_n;
            din_a    <= din_a_n;
            we_a     <= we_a_n;
            addr_b   <= addr_b_n;
            re_b     <= re_b_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            fail     <= fail_n;
            err_cnt  <= err_cnt_n;
            err_addr <= err_addr_n;
            err_data <= err_data_n;
            drn_cnt  <= drn_n;
            vld_pipe[0] <= re_b_n;
            adr_pipe[0] <= addr_b_n;
            exp_pipe[0] <= pat(addr_b_n, state_n == RD2);
            for (int i = RD_LAT; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Scoreboard bench for dpram_bist_ctrl: a RAM model with injectable faults, expected
// port traffic and final status queued by the stimulus and checked by a negedge monitor.
module tb_dpram_bist_ctrl;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] addr_a, addr_b, err_addr;
    logic [7:0] din_a, din_b, dout_b, err_data;
    logic       we_a, re_a, we_b, re_b, busy, done, pass, fail;
    logic [5:0] err_cnt;

    always #5 clk = ~clk;

    dpram_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .re_a(re_a),
        .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .re_b(re_b),
        .dout_b(dout_b), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .err_cnt(err_cnt), .err_addr(err_addr), .err_data(err_data)
    );

    // k ^ 8'hA5 for k = 0..15
    logic [7:0] d1_tab [16] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                                8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA};

    typedef struct {
        logic       ps, fl;
        logic [5:0] cnt;
        logic [3:0] ea;
        logic [7:0] ed;
    } res_t;

    logic [11:0] wq[$];
    logic [3:0]  rq[$];
    res_t        resq[$];

    int checks = 0, errors = 0;
    int cyc = 0, start_edge = 0, fault = 0;
    logic done_q = 1'b0;

    // RAM model, one-cycle read latency; fault 1 sticks mem[7] bit3 low, fault 2 inverts reads.
    logic [7:0] mem [16];
    logic [7:0] rd = 8'h00;
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= (fault == 1 && addr_a == 4'd7) ? (din_a & 8'hF7) : din_a;
        if (re_b) rd <= (fault == 2) ? ~mem[addr_b] : mem[addr_b];
    end
    assign dout_b = rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        res_t r;
        logic [11:0] w;
        chk("protocol", {we_a & re_b, re_a, we_b}, 3'b000);
        if (we_a) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                w = wq.pop_front();
                chk("addr_a", {28'd0, addr_a}, {28'd0, w[11:8]});
                chk("din_a", {24'd0, din_a}, {24'd0, w[7:0]});
            end
        end
        if (re_b) begin
            if (rq.size() == 0) chk("unexpected_read", 1, 0);
            else chk("addr_b", {28'd0, addr_b}, {28'd0, rq.pop_front()});
        end
        if (done && !done_q) begin
            if (resq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                r = resq.pop_front();
                chk("latency", cyc - start_edge, 68);
                chk("busy_at_done", {31'd0, busy}, 0);
                chk("pass", {31'd0, pass}, {31'd0, r.ps});
                chk("fail", {31'd0, fail}, {31'd0, r.fl});
                chk("err_cnt", {26'd0, err_cnt}, {26'd0, r.cnt});
                chk("err_addr", {28'd0, err_addr}, {28'd0, r.ea});
                chk("err_data", {24'd0, err_data}, {24'd0, r.ed});
            end
        end
        done_q <= done;
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start_edge = cyc; start = 1'b0;
    endtask

    task automatic run(input int f, input logic ps, input logic fl, input logic [5:0] cnt,
                       input logic [3:0] ea, input logic [7:0] ed, input bit extra);
        bit seen = 0;
        res_t r;
        fault = f;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 16; k++) begin
                wq.push_back({4'(k), p == 0 ? d1_tab[k] : ~d1_tab[k]});
                rq.push_back(4'(k));
            end
        r.ps = ps; r.fl = fl; r.cnt = cnt; r.ea = ea; r.ed = ed;
        resq.push_back(r);
        pulse_start();
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (extra && cyc - start_edge == 20) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_hold", {31'd0, done}, 1);
        chk("pass_hold", {31'd0, pass}, {31'd0, ps});
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("res_drained", resq.size(), 0);
        wq.delete(); rq.delete(); resq.delete();
    endtask

    initial begin
        bit hit = 0;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {we_a, re_b, busy, done, pass, fail, err_cnt, err_addr, err_data, addr_a, din_a},
            '0);
        rst = 1'b0;

        run(0, 1'b1, 1'b0, 6'd0,  4'd0, 8'h00, 0);   // healthy RAM
        run(1, 1'b0, 1'b1, 6'd1,  4'd7, 8'h55, 0);   // mem[7] bit3 stuck low
        run(2, 1'b0, 1'b1, 6'd32, 4'd0, 8'h5A, 0);   // every read inverted
        run(0, 1'b1, 1'b0, 6'd0,  4'd0, 8'h00, 1);   // extra start mid-run ignored

        // Reset in WR1 once addr_a reaches 5; only writes 0..5 are expected.
        fault = 0;
        for (int k = 0; k < 6; k++) wq.push_back({4'(k), d1_tab[k]});
        pulse_start();
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (we_a && addr_a == 4'd5) hit = 1;
        end
        if (!hit) chk("addr5_timeout", 0, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_mid_we_a", {31'd0, we_a}, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_re_b", {31'd0, re_b}, 0);
        chk("rst_mid_err_cnt", {26'd0, err_cnt}, 0);
        @(negedge clk);
        chk("rst_wq_drained", wq.size(), 0);
        wq.delete();

        run(0, 1'b1, 1'b0, 6'd0, 4'd0, 8'h00, 0);    // fresh run after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpram_bist_ctrl.md
Name: dpram_bist_ctrl

Overview:
- Built-in self-test sequencer that acts as the initiator on our 16x8 single-clock dual-port RAM interface.
- Port A issues all writes; port B issues all reads.
- Runs a two-pass write/read-back pattern test, compares port B read data against expected values, and reports pass/fail plus first-error diagnostics.
- Sits beside the RAM; the system asserts start at bring-up or on demand.

Parameters:
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- SEED, 8'hA5, pattern seed (low DATA_W bits used).
- RD_LAT, 1, RAM read latency: edges from the RAM sampling re_b/addr_b to dout_b valid.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin test; sampled only in IDLE.
- addr_a  out  ADDR_W  port A address.
- din_a  out  DATA_W  port A write data.
- we_a  out  1  port A write enable.
- re_a  out  1  port A read enable, constant 0.
- addr_b  out  ADDR_W  port B address.
- din_b  out  DATA_W  port B write data, constant 0.
- we_b  out  1  port B write enable, constant 0.
- re_b  out  1  port B read enable.
- dout_b  in  DATA_W  port B read data from RAM.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start or rst.
- pass  out  1  done and no mismatch.
- fail  out  1  sticky, at least one mismatch this run.
- err_cnt  out  ADDR_W+2  mismatch count; max 2*DEPTH, so it cannot overflow.
- err_addr  out  ADDR_W  address of first mismatch.
- err_data  out  DATA_W  observed dout_b at first mismatch.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: all outputs 0; state IDLE; internal counters and compare pipeline cleared.
- Registers: all RAM-side outputs are registered.
- Pattern:
  - d1(k) = zero-extended k XOR SEED, truncated to DATA_W.
  - d2(k) = ~d1(k).
- States:
  - IDLE: start=1 -> WR1. At that edge: busy=1; done, pass, fail, err_* cleared; we_a=1, addr_a=0, din_a=d1(0).
  - WR1: one write per cycle, addr_a 0..DEPTH-1. After the last write -> RD1; we_a=0 and re_b=1, addr_b=0 at the same edge.
  - RD1: one read per cycle, addr_b 0..DEPTH-1. After the last read -> DRN1; re_b=0.
  - DRN1: wait RD_LAT+1 edges for outstanding compares -> WR2.
  - WR2, RD2, DRN2: identical to pass 1, using d2.
  - End of DRN2 -> DONE: busy=0, done=1, pass=!fail. DONE -> IDLE next cycle; done/pass/fail/err_* hold.
- Compare pipeline:
  - A read launched at edge E (re_b, addr_b registered) is sampled by the RAM at E+1.
  - dout_b is compared at edge E+1+RD_LAT.
  - A valid/address/expected shift register of depth RD_LAT+1 carries each launched read.
- On mismatch: fail=1 (sticky); err_cnt += 1. On the first mismatch only, err_addr and err_data are captured.
- Exclusivity: we_a and re_b are never both 1; re_a and we_b are always 0.
- Back-to-back: the addr_a/addr_b counter wraps DEPTH-1 -> 0 only at phase transitions, never mid-phase.
- Latency: done rises 2*(2*DEPTH+RD_LAT+1) edges after start is sampled; 68 at defaults.
- start while busy: ignored, no effect.
- start held high through DONE: a new run begins from IDLE.
- rst mid-operation: at that edge we_a=0, re_b=0, all status cleared, IDLE; in-flight compares are discarded.

Test Plan:
- Healthy RAM, defaults, pulse start -> addr_a 0..15 with din_a 0xA5,0xA4,0xA7,...,0xAA; reads 0..15 on port B; done=1 and pass=1 at 68 cycles; err_cnt=0.
- RAM model forces mem[7] bit3=0 -> pass 1 clean (d1(7)=0xA2); pass 2 mismatch -> fail=1, err_cnt=1, err_addr=7, err_data=0x55, pass=0.
- RAM model inverts all reads -> err_cnt=32, err_addr=0, err_data=0x5A, fail=1.
- start pulsed again at cycle 20 of a run -> ignored; done still at cycle 68 of the original run; single run's results.
- rst asserted during WR1 at addr_a=5 -> next edge: we_a=0, busy=0, err_cnt=0, state IDLE; a fresh start then yields a full 68-cycle pass.
- Protocol check over all scenarios: we_a and re_b never both 1; we_b=0 and re_a=0 throughout.
